// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDR SDRAM responder.
// - cmd_e    : {nRAS,nCAS,nSWE} command encodings
// - err_e    : protocol violation codes reported on err_code
// - rd_slot_t: one stage of the read latency pipeline
// - cl_legal : CAS latencies this device accepts in LOAD MODE
package sdram_pkg;

  localparam int ROW_W  = 13;
  localparam int COL_W  = 9;
  localparam int BANK_W = 2;
  localparam int NBANK  = 4;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,  // burst terminate: bursts are single, so it acts as NOP
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_IDLE_BANK  = 3'd1,  // RD/WR to a bank with no open row
    ERR_ACT_ACTIVE = 3'd2,  // ACT to a bank that already has an open row
    ERR_BANK_OPEN  = 3'd3,  // REF/LMR while any bank is open
    ERR_BAD_MODE   = 3'd4,  // LMR with unsupported CL or burst length
    ERR_LANE       = 3'd5,  // RD/WR with both or neither byte lane selected
    ERR_NO_MODE    = 3'd6   // RD/WR before the first LOAD MODE
  } err_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } rd_slot_t;

  function automatic logic cl_legal(input logic [2:0] cl);
    return (cl == 3'd2) || (cl == 3'd3);
  endfunction

endpackage

// File: rtl/sdram_bank_tracker.sv
// sdram_bank_tracker: open/closed state and open row of the four banks.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   act               open bank 'bank' at row 'row_in'
//   pre               close bank 'bank' (explicit PRE or auto-precharge)
//   pre_all           close every bank
//   bank, row_in      bank select and row for ACT
//   active            per-bank open flags
//   row               open row of bank 'bank' (combinational lookup)
module sdram_bank_tracker
  import sdram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              act,
  input  logic              pre,
  input  logic              pre_all,
  input  logic [BANK_W-1:0] bank,
  input  logic [ROW_W-1:0]  row_in,
  output logic [NBANK-1:0]  active,
  output logic [ROW_W-1:0]  row
);

  logic [ROW_W-1:0] rows [NBANK];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= '0;
      for (int i = 0; i < NBANK; i++) rows[i] <= '0;
    end else if (act) begin
      // An ACT to an already open bank replaces the row (the error is
      // flagged by the caller).
      active[bank] <= 1'b1;
      rows[bank]   <= row_in;
    end else if (pre_all) begin
      active <= '0;
    end else if (pre) begin
      active[bank] <= 1'b0;
    end
  end

  assign row = rows[bank];

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: SDR x16 SDRAM target emulated on a byte-wide BRAM.
// Ports:
//   C25M, RES              clock, asynchronous active-high reset
//   RCKE                   clock enable, takes effect one edge later
//   nRCS,nRAS,nCAS,nSWE    command pins; SBA bank; SA row/column/mode
//   DQML, DQMH             active-low lane selects (exactly one must be low)
//   SD_in / SD_out, SD_oe  write data in; read data out with drive enable
//   mem_addr, mem_rd, mem_wr, mem_wdata, mem_rdata   external BRAM port
//   mode_reg, mode_set     last accepted LOAD MODE value and its flag
//   ref_cnt                auto-refresh counter (wraps)
//   proto_err, err_code    sticky flag and code of the first violation
// BRAM interface: mem_rd is a combinational strobe in the cycle a legal RD
// is on the pins; mem_rdata is valid the cycle after and held until the
// next mem_rd. mem_wr is a registered one-clock strobe with its own address.
// MEM_AW must not exceed 25 (the full {bank,row,col,lane} width).
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int         MEM_AW   = 16,
  parameter logic [2:0] CL_RESET = 3'd2
) (
  input  logic              C25M,
  input  logic              RES,
  input  logic              RCKE,
  input  logic              nRCS,
  input  logic              nRAS,
  input  logic              nCAS,
  input  logic              nSWE,
  input  logic [1:0]        SBA,
  input  logic [12:0]       SA,
  input  logic              DQML,
  input  logic              DQMH,
  input  logic [7:0]        SD_in,
  output logic [7:0]        SD_out,
  output logic              SD_oe,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [12:0]       mode_reg,
  output logic              mode_set,
  output logic [15:0]       ref_cnt,
  output logic              proto_err,
  output logic [2:0]        err_code
);

  logic              ce;
  logic [2:0]        cl;
  cmd_e              cmd;
  err_e              viol;
  logic [NBANK-1:0]  active;
  logic [ROW_W-1:0]  bank_row;
  logic [MEM_AW-1:0] acc_addr;
  logic              acc_ok;
  logic              lmr_ok;
  logic              wr_pend;
  logic [MEM_AW-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              rd_s0;   // read issued at the previous ce edge
  rd_slot_t          rd_s1;   // BRAM data captured one ce edge later

  // Commands are only decoded on edges where the registered clock enable is high.
  always_comb begin
    cmd = CMD_NOP;
    if (ce && !nRCS) cmd = cmd_e'({nRAS, nCAS, nSWE});
  end

  // Checks are ordered by code so simultaneous faults report the lowest one.
  always_comb begin
    viol = ERR_NONE;
    case (cmd)
      CMD_RD, CMD_WR: begin
        if (!active[SBA])      viol = ERR_IDLE_BANK;
        else if (DQML == DQMH) viol = ERR_LANE;
        else if (!mode_set)    viol = ERR_NO_MODE;
      end
      CMD_ACT: if (active[SBA]) viol = ERR_ACT_ACTIVE;
      CMD_REF: if (|active)     viol = ERR_BANK_OPEN;
      CMD_LMR: begin
        if (|active) viol = ERR_BANK_OPEN;
        else if (!cl_legal(SA[6:4]) || (SA[2:0] != 3'd0)) viol = ERR_BAD_MODE;
      end
      default: ;
    endcase
  end

  // Illegal accesses touch neither the BRAM nor the bank state.
  assign acc_ok = ((cmd == CMD_RD) || (cmd == CMD_WR)) && (viol == ERR_NONE);
  assign lmr_ok = (cmd == CMD_LMR) && (viol == ERR_NONE);

  // Lane 1 (high byte) is addressed whenever DQML is deasserted.
  assign acc_addr = MEM_AW'({SBA, bank_row, SA[COL_W-1:0], DQML});

  sdram_bank_tracker u_banks (
    .clk     (C25M),
    .rst     (RES),
    .act     (cmd == CMD_ACT),
    .pre     (((cmd == CMD_PRE) && !SA[10]) || (acc_ok && SA[10])),
    .pre_all ((cmd == CMD_PRE) && SA[10]),
    .bank    (SBA),
    .row_in  (SA),
    .active  (active),
    .row     (bank_row)
  );

  assign mem_rd    = acc_ok && (cmd == CMD_RD);
  assign mem_wr    = wr_pend;
  assign mem_wdata = wr_data;
  // A pending write owns the address bus; controllers leave a gap after WR.
  assign mem_addr  = wr_pend ? wr_addr : acc_addr;

  always_ff @(posedge C25M or posedge RES) begin
    if (RES) begin
      ce        <= 1'b0;
      cl        <= CL_RESET;
      mode_reg  <= '0;
      mode_set  <= 1'b0;
      ref_cnt   <= '0;
      proto_err <= 1'b0;
      err_code  <= '0;
      wr_pend   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_s0     <= 1'b0;
      rd_s1     <= '0;
      SD_out    <= '0;
      SD_oe     <= 1'b0;
    end else begin
      ce      <= RCKE;
      wr_pend <= acc_ok && (cmd == CMD_WR);
      if (acc_ok && (cmd == CMD_WR)) begin
        wr_addr <= acc_addr;
        wr_data <= SD_in;
      end
      // REF counts even when it is also flagged as a violation.
      if (cmd == CMD_REF) ref_cnt <= ref_cnt + 16'd1;
      if (lmr_ok) begin
        mode_reg <= SA;
        mode_set <= 1'b1;
        cl       <= SA[6:4];
      end
      if (!proto_err && (viol != ERR_NONE)) begin
        proto_err <= 1'b1;
        err_code  <= viol;
      end
      // Read pipeline advances on ce edges only; the BRAM output is stable
      // across ce=0 edges because mem_rd cannot fire there.
      if (ce) begin
        rd_s0 <= mem_rd;
        rd_s1 <= '{valid: rd_s0, data: mem_rdata};
        if ((cl == 3'd2) && rd_s0) begin
          SD_out <= mem_rdata;
          SD_oe  <= 1'b1;
        end else if ((cl == 3'd3) && rd_s1.valid) begin
          SD_out <= rd_s1.data;
          SD_oe  <= 1'b1;
        end else begin
          SD_oe  <= 1'b0;
        end
      end
    end
  end

endmodule
